paint_frame_buffer: RTL
=======================

PAINT_FRAME_BUFFER -- requirements
Module: paint_frame_buffer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: drawable width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 360: drawable height in pixels.
REQ-003 SHALL have parameter NUM_BRUSHES, default 2, range 1-4: number of independent brush channels.
REQ-004 SHALL have parameter COLOR_WIDTH, default 4: stored color-code width.
REQ-005 SHALL have one clock, pixel_clk_in, and an asynchronous, active-high reset, rst_in.
REQ-006 Ports SHALL be as follows:
- pixel_clk_in  in  1  pixel clock.
- rst_in  in  1  async active-high reset.
- hcount_in  in  10  scan column.
- vcount_in  in  9  scan row.
- nf_in  in  1  new-frame pulse, one cycle.
- x_in  in  10*NUM_BRUSHES  packed brush-centre columns; brush i is at [10i+9:10i].
- y_in  in  9*NUM_BRUSHES  packed brush-centre rows.
- color_in  in  COLOR_WIDTH*NUM_BRUSHES  packed brush color codes.
- size_in  in  3*NUM_BRUSHES  packed brush size codes.
- brush_en_in  in  NUM_BRUSHES  per-brush pen-down.
- clear_in  in  1  clear-canvas request pulse.
- red_out, green_out, blue_out  out  8 each  registered pixel color.
- busy_out  out  1  high while a clear is pending or running.

Function
REQ-007 Canvas SHALL be a dual-port RAM of H_ACTIVE*V_ACTIVE words of COLOR_WIDTH bits: one write port and one read port, both on pixel_clk_in.
REQ-008 Scan address SHALL be hcount_in + H_ACTIVE*vcount_in; it SHALL be valid only when hcount_in<H_ACTIVE and vcount_in<V_ACTIVE.
REQ-009 Brush i radius SHALL be r = 2*(size+1)-1, giving 1..15.
REQ-010 The brush i hit test SHALL be dx*dx + dy*dy <= r*r.
- dx and dy are signed differences between scan and centre.
- The arithmetic SHALL be signed, 24-bit, with no overflow.
REQ-011 A brush SHALL hit only if its brush_en_in bit is high and the scan address is valid.
REQ-012 When several brushes hit, the lowest-index brush SHALL win and write its color; the others SHALL be dropped that cycle.
REQ-013 Brush writes SHALL occur in the same cycle the scan position is presented.
REQ-014 Readout SHALL be fixed latency: RGB for scan (h,v) SHALL appear exactly 3 cycles after (h,v) is presented (2-cycle RAM plus palette register).
REQ-015 Within that latency, a same-cycle write at (h,v) SHALL be read-first, so it is visible on the next frame.
REQ-016 Palette (code -> R,G,B) SHALL be:
- 0 -> 00,00,00
- 1 -> FF,FF,FF
- 2 -> FF,00,00
- 3 -> 00,FF,00
- 4 -> 00,00,FF
- 5 -> 00,FF,FF
- 6 -> FF,00,FF
- 7 -> FF,FF,00
- 8 -> 80,80,80
- any other code -> FF,FF,FF
REQ-017 Outside the valid scan area, the output SHALL be 00,00,00 (same latency).
REQ-018 The clear FSM SHALL have states IDLE, ARMED and CLEAR.
- IDLE -> ARMED on clear_in.
- ARMED -> CLEAR on the next nf_in.
- CLEAR writes code 0 at counter addresses 0..H_ACTIVE*V_ACTIVE-1, one per cycle, independent of the scan.
- CLEAR -> IDLE after writing the last address.
REQ-019 busy_out SHALL be high in ARMED and CLEAR.
REQ-020 In CLEAR, all brush writes SHALL be suppressed.
REQ-021 In ARMED, brush writes SHALL proceed normally.
REQ-022 clear_in SHALL be ignored while in ARMED or CLEAR.
REQ-023 If clear_in and nf_in are high in the same cycle in IDLE, the FSM SHALL go to ARMED only; it SHALL wait for the following nf_in.
REQ-024 The clear counter SHALL stop at the last address; it SHALL NOT wrap.

Reset
REQ-025 On rst_in, and at any time including mid-clear, the following SHALL be forced asynchronously:
- FSM to IDLE;
- clear counter to 0;
- busy_out to 0;
- red_out, green_out and blue_out to 0;
- the read pipeline to invalid.
REQ-026 RAM contents SHALL NOT be reset; a clear interrupted by reset leaves the canvas partially cleared.
REQ-027 Outputs SHALL be 0 for the first 3 cycles after reset deassertion.

Configuration
REQ-028 The macro CURSOR_OVERLAY_EN SHALL control a cursor overlay.
- Defined: an output pixel inside any enabled-or-disabled brush disk SHALL be shown as bitwise-inverted palette RGB, aligned to the same 3-cycle latency; the RAM is unaffected.
- Undefined: no overlay logic SHALL exist, and the output is palette RGB only.

Verification
REQ-029 Paint, single brush: NUM_BRUSHES=2, brush0 at (100,50), size 0 (r=1), color 2, enabled, one full frame.
- Next frame (100,50),(101,50),(100,51) read FF,00,00.
- (102,50) reads the prior value.
REQ-030 Priority: brush0 and brush1 both at (200,100), size 1, colors 3 and 4, both enabled.
- Next frame (200,100) reads 00,FF,00.
REQ-031 Latency: present (10,10), holding code 8.
- Exactly 3 cycles later the output is 80,80,80.
- Code 12 gives FF,FF,FF.
REQ-032 Clear: pulse clear_in.
- busy_out rises next cycle; the FSM waits in ARMED until nf_in.
- Then 230400 cycles of CLEAR, with brushes enabled but no writes.
- busy_out then falls, and the whole next frame reads 00,00,00.
REQ-033 Reset mid-clear: assert rst_in 1000 cycles into CLEAR.
- busy_out and the outputs go 0 immediately.
- The FSM is IDLE, and a new clear_in re-arms it.
REQ-034 Boundary: hcount_in=640 with a brush enabled.
- No write, and the output is 00,00,00.
- A brush at (0,0), r=3 writes no out-of-range addresses.

Source files
------------

// File: rtl/paint_frame_buffer.sv
// paint_frame_buffer: multi-brush paint canvas with a frame-synchronised clear FSM and a 3-cycle RGB readout.
// Define CURSOR_OVERLAY_EN to invert output pixels that lie inside any brush disk.
module paint_frame_buffer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 360,
  parameter int NUM_BRUSHES = 2,
  parameter int COLOR_WIDTH = 4
) (
  input  logic                               pixel_clk_in,
  input  logic                               rst_in,
  input  logic [9:0]                         hcount_in,
  input  logic [8:0]                         vcount_in,
  input  logic                               nf_in,
  input  logic [10*NUM_BRUSHES-1:0]          x_in,
  input  logic [9*NUM_BRUSHES-1:0]           y_in,
  input  logic [COLOR_WIDTH*NUM_BRUSHES-1:0] color_in,
  input  logic [3*NUM_BRUSHES-1:0]           size_in,
  input  logic [NUM_BRUSHES-1:0]             brush_en_in,
  input  logic                               clear_in,
  output logic [7:0]                         red_out,
  output logic [7:0]                         green_out,
  output logic [7:0]                         blue_out,
  output logic                               busy_out
);
  localparam int DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ARMED, CLEAR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, scan_addr, waddr;
  logic [COLOR_WIDTH-1:0] mem [DEPTH];
  logic [COLOR_WIDTH-1:0] rd1_q, rd2_q, wdata, brush_color;
  logic [NUM_BRUSHES-1:0] geo;
  logic scan_ok, we, brush_we;
  logic [1:0] vld_q;
  logic [23:0] rgb_q, pal, mask;
  assign scan_ok = (32'(hcount_in) < H_ACTIVE) && (32'(vcount_in) < V_ACTIVE);
  assign scan_addr = AW'(32'(hcount_in) + H_ACTIVE * 32'(vcount_in));
  for (genvar i = 0; i < NUM_BRUSHES; i++) begin : g_brush
    logic signed [23:0] dx, dy, d2;
    logic [3:0] r;
    logic [7:0] rr;
    assign dx = $signed({14'd0, hcount_in}) - $signed({14'd0, x_in[10*i +: 10]});
    assign dy = $signed({15'd0, vcount_in}) - $signed({15'd0, y_in[9*i +: 9]});
    assign d2 = dx * dx + dy * dy;
    assign r = {size_in[3*i +: 3], 1'b1};
    assign rr = {4'd0, r} * {4'd0, r};
    assign geo[i] = d2 <= $signed({16'd0, rr});
  end
  // Walk from the top index down so the lowest-index hitting brush is left standing.
  always_comb begin
    brush_we = 1'b0;
    brush_color = '0;
    for (int b = NUM_BRUSHES - 1; b >= 0; b--)
      if (geo[b] && brush_en_in[b] && scan_ok) begin
        brush_we = 1'b1;
        brush_color = color_in[COLOR_WIDTH*b +: COLOR_WIDTH];
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = clear_in ? ARMED : IDLE;
      ARMED: begin
        cnt_d = '0;
        state_d = nf_in ? CLEAR : ARMED;
      end
      CLEAR: begin
        state_d = (cnt_q == LAST) ? IDLE : CLEAR;
        cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign we = (state_q == CLEAR) || brush_we;
  assign waddr = (state_q == CLEAR) ? cnt_q : scan_addr;
  assign wdata = (state_q == CLEAR) ? '0 : brush_color;
  assign busy_out = state_q != IDLE;
  // Read-first: the read samples the old word when a write hits the same address.
  always_ff @(posedge pixel_clk_in) begin
    if (we) mem[waddr] <= wdata;
    rd1_q <= mem[scan_ok ? scan_addr : '0];
    rd2_q <= rd1_q;
  end
  always_comb
    case (32'(rd2_q))
      0: pal = 24'h000000;
      2: pal = 24'hFF0000;
      3: pal = 24'h00FF00;
      4: pal = 24'h0000FF;
      5: pal = 24'h00FFFF;
      6: pal = 24'hFF00FF;
      7: pal = 24'hFFFF00;
      8: pal = 24'h808080;
      default: pal = 24'hFFFFFF;
    endcase
`ifdef CURSOR_OVERLAY_EN
  logic [1:0] cur_q;
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) cur_q <= '0;
    else cur_q <= {cur_q[0], |geo};
  assign mask = {24{cur_q[1]}};
`else
  assign mask = '0;
`endif
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vld_q <= '0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= {vld_q[0], scan_ok};
      rgb_q <= vld_q[1] ? pal ^ mask : '0;
    end
  assign {red_out, green_out, blue_out} = rgb_q;
endmodule
